// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the 200x150 RGB444 frame buffer and the write-side
// controller state type. The display-side blocks reuse the same constants.
//   H_LEN / V_LEN : image width / height in pixels
//   AW / DW       : VRAM address width / pixel width
//   TOTAL         : number of pixels in one frame
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int H_LEN = 200;
    localparam int V_LEN = 150;
    localparam int AW    = 15;
    localparam int DW    = 12;
    localparam int TOTAL = H_LEN * V_LEN;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/vram_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_wr_arbiter_if
// Bundles the two requester handshakes and the VRAM port-B write bus.
//   master : requester side (drives valid/addr/data, sees ready and port B)
//   slave  : arbiter side   (sees requests, drives ready, port B and err_oob)
// -----------------------------------------------------------------------------
interface vram_wr_arbiter_if #(
    parameter int AW = vga_pkg::AW,
    parameter int DW = vga_pkg::DW
);

    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;

    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;

    logic          web;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dinb;
    logic          err_oob;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  web, addrb, dinb, err_oob
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output web, addrb, dinb, err_oob
    );

endinterface

// File: rtl/vram_wr_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. A lone valid requester is granted; when both are
// valid the pointer decides. After a transfer the pointer moves to the other
// requester; without a transfer it holds.
//   pclk, rstn : clock, async active-low reset
//   valid[1:0] : request lines
//   en         : grants allowed this cycle
//   xfer       : a granted request was taken at this edge
//   gnt[1:0]   : one-hot (or zero) grant
//   ptr        : requester favoured on contention (0 = req0)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       pclk,
    input  logic       rstn,
    input  logic [1:0] valid,
    input  logic       en,
    input  logic       xfer,
    output logic [1:0] gnt,
    output logic       ptr
);

    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            ptr <= 1'b0;
        end else if (xfer) begin
            // Point at whichever requester did not just transfer.
            ptr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/vram_wr_arbiter.sv
// -----------------------------------------------------------------------------
// vram_wr_arbiter
// Shares VRAM write port B between two pixel requesters and runs a full-frame
// clear engine. Requests are registered onto port B one cycle after transfer;
// out-of-range addresses are consumed and flagged instead of written.
//   pclk, rstn      : pixel clock, async active-low reset
//   clr_start       : one-cycle request to fill the frame with clr_color
//   clr_color       : fill colour, sampled when clr_start is accepted
//   clr_busy        : clear in progress (covers every clear write cycle)
//   clr_done        : pulses with the final clear write
//   bus (slave)     : requester handshakes, port-B web/addrb/dinb, err_oob
// -----------------------------------------------------------------------------
module vram_wr_arbiter #(
    parameter int AW    = vga_pkg::AW,
    parameter int DW    = vga_pkg::DW,
    parameter int H_LEN = vga_pkg::H_LEN,
    parameter int V_LEN = vga_pkg::V_LEN
) (
    input  logic                pclk,
    input  logic                rstn,
    input  logic                clr_start,
    input  logic [DW-1:0]       clr_color,
    output logic                clr_busy,
    output logic                clr_done,
    vram_wr_arbiter_if.slave    bus
);

    import vga_pkg::state_t;
    import vga_pkg::ST_IDLE;
    import vga_pkg::ST_CLEAR;

    localparam int            TOTAL   = H_LEN * V_LEN;
    localparam int            AW1     = AW + 1;
    localparam logic [AW:0]   TOTAL_W = AW1'(TOTAL);
    localparam logic [AW-1:0] LAST    = AW'(TOTAL - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;
    logic [DW-1:0] color;

    logic          clr_go;
    logic          clr_last;
    logic [AW-1:0] clr_addr;
    logic [DW-1:0] clr_data;

    logic [1:0]    valid;
    logic [1:0]    gnt;
    logic          arb_en;
    logic          xfer;
    logic          arb_ptr;
    logic          sel;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          req_oob;

    logic          web_q;
    logic [AW-1:0] addrb_q;
    logic [DW-1:0] dinb_q;
    logic          err_q;
    logic          done_q;

    // ---------------- arbitration ----------------
    assign valid  = {bus.req1_valid, bus.req0_valid};
    // Readies are forced low under reset and whenever a clear owns port B,
    // including the cycle in which clr_start is being accepted.
    assign arb_en = rstn && (state == ST_IDLE) && !clr_start;
    assign xfer   = |gnt;

    rr_arb2 u_rr_arb2 (
        .pclk  (pclk),
        .rstn  (rstn),
        .valid (valid),
        .en    (arb_en),
        .xfer  (xfer),
        .gnt   (gnt),
        .ptr   (arb_ptr)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    // Data mux select mirrors the grant decision but ignores en, keeping the
    // FSM and clr_start off the address/data path.
    assign sel      = valid[1] & (~valid[0] | arb_ptr);
    assign req_addr = sel ? bus.req1_addr : bus.req0_addr;
    assign req_data = sel ? bus.req1_data : bus.req0_data;
    assign req_oob  = {1'b0, req_addr} >= TOTAL_W;

    // ---------------- clear FSM ----------------
    // cnt tracks the address currently presented on port B during a clear,
    // so the last write is on the bus while the FSM is still in ST_CLEAR.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_go    = 1'b0;
        clr_addr  = '0;
        case (state)
            ST_IDLE: begin
                if (clr_start) begin
                    state_nxt = ST_CLEAR;
                    clr_go    = 1'b1;
                    clr_addr  = '0;
                    cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt == LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    clr_go   = 1'b1;
                    clr_addr = cnt + AW'(1);
                    cnt_nxt  = clr_addr;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign clr_last = clr_go && (clr_addr == LAST);
    // The colour register is only loaded at the accept edge, so the first
    // write takes the input directly.
    assign clr_data = (state == ST_IDLE) ? clr_color : color;
    assign clr_busy = (state == ST_CLEAR);

    // ---------------- output register stage ----------------
    // NOTE: address/data registers are reset as well so port B reads as all
    // zeros during and after reset, not just with web low.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            color   <= '0;
            web_q   <= 1'b0;
            addrb_q <= '0;
            dinb_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            web_q  <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            if ((state == ST_IDLE) && clr_start) color <= clr_color;
            if (clr_go) begin
                web_q   <= 1'b1;
                addrb_q <= clr_addr;
                dinb_q  <= clr_data;
                done_q  <= clr_last;
            end else if (xfer) begin
                if (req_oob) begin
                    err_q <= 1'b1;
                end else begin
                    web_q   <= 1'b1;
                    addrb_q <= req_addr;
                    dinb_q  <= req_data;
                end
            end
        end
    end

    assign bus.web     = web_q;
    assign bus.addrb   = addrb_q;
    assign bus.dinb    = dinb_q;
    assign bus.err_oob = err_q;
    assign clr_done    = done_q;

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_wr_arbiter
// Directed and randomized stimulus against a cycle-level reference model.
// The model predicts readies, busy and every port-B event; predicted events
// go into a scoreboard queue stamped with the cycle they must appear in, and
// an independent monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_vram_wr_arbiter;
    import vga_pkg::*;

    localparam int TOT = TOTAL;

    logic          pclk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_color = '0;
    logic          clr_busy;
    logic          clr_done;

    vram_wr_arbiter_if bus ();

    vram_wr_arbiter dut (
        .pclk      (pclk),
        .rstn      (rstn),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .bus       (bus)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        int            cyc;
        bit            err;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            done;
    } exp_t;

    req_t q0[$];
    req_t q1[$];
    exp_t exp_q[$];
    bit   start_pending = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- requester / clear driver ----------------
    initial begin
        bit hs0, hs1;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        forever begin
            @(negedge pclk);
            hs0 = bus.req0_valid && bus.req0_ready;
            hs1 = bus.req1_valid && bus.req1_ready;
            @(posedge pclk);
            #1;
            if (hs0 && q0.size() > 0) q0.delete(0);
            if (hs1 && q1.size() > 0) q1.delete(0);
            clr_start     = start_pending;
            start_pending = 1'b0;
            if (q0.size() > 0) begin
                bus.req0_valid = 1'b1; bus.req0_addr = q0[0].addr; bus.req0_data = q0[0].data;
            end else begin
                bus.req0_valid = 1'b0; bus.req0_addr = AW'($urandom); bus.req0_data = DW'($urandom);
            end
            if (q1.size() > 0) begin
                bus.req1_valid = 1'b1; bus.req1_addr = q1[0].addr; bus.req1_data = q1[0].data;
            end else begin
                bus.req1_valid = 1'b0; bus.req1_addr = AW'($urandom); bus.req1_data = DW'($urandom);
            end
        end
    end

    // ---------------- reference model ----------------
    // Rules: clear owns the port for TOT cycles starting the cycle after
    // acceptance; otherwise a lone requester wins, contention goes to whoever
    // did not win last, and accepted writes appear one cycle later.
    initial begin
        bit ptr_m = 1'b0;
        int busy_from = 0;
        int busy_to = -1;
        bit busy_now, r0, r1;
        exp_t e;
        forever begin
            @(negedge pclk);
            if (!rstn) begin
                exp_q.delete();
                ptr_m = 1'b0;
                busy_to = -1;
            end else begin
                busy_now = (cyc >= busy_from) && (cyc <= busy_to);
                check("clr_busy", clr_busy, busy_now);
                r0 = 1'b0;
                r1 = 1'b0;
                if (!busy_now && !clr_start) begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        r0 = !ptr_m;
                        r1 = ptr_m;
                    end else begin
                        r0 = bus.req0_valid;
                        r1 = bus.req1_valid;
                    end
                end
                check("readies", {bus.req1_ready, bus.req0_ready}, {r1, r0});
                if (!busy_now && clr_start) begin
                    for (int k = 0; k < TOT; k++) begin
                        e.cyc = cyc + 1 + k; e.err = 1'b0; e.addr = AW'(k);
                        e.data = clr_color; e.done = (k == TOT - 1);
                        exp_q.push_back(e);
                    end
                    busy_from = cyc + 1;
                    busy_to   = cyc + TOT;
                end else if (r0 || r1) begin
                    e.cyc  = cyc + 1;
                    e.addr = r1 ? bus.req1_addr : bus.req0_addr;
                    e.data = r1 ? bus.req1_data : bus.req0_data;
                    e.err  = (int'(e.addr) >= TOT);
                    e.done = 1'b0;
                    exp_q.push_back(e);
                    ptr_m = r0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (!rstn) begin
                check("reset_outputs",
                      {clr_busy, clr_done, bus.req0_ready, bus.req1_ready,
                       bus.web, bus.err_oob, bus.addrb, bus.dinb}, 64'd0);
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                if (e.err)
                    check("oob_event", {bus.web, bus.err_oob, clr_done}, 3'b010);
                else
                    check("write", {bus.web, bus.err_oob, clr_done, bus.addrb, bus.dinb},
                          {1'b1, 1'b0, e.done, e.addr, e.data});
            end else begin
                check("no_write", {bus.web, bus.err_oob, clr_done}, 3'b000);
            end
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic drain(input int budget);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !start_pending && !clr_start
                 && exp_q.size() == 0) && n < budget) begin
            @(negedge pclk);
            #1;
            n++;
        end
        check("drain_pending", q0.size() + q1.size() + exp_q.size() + int'(start_pending), 0);
        repeat (3) @(negedge pclk);
    endtask

    task automatic reset_pulse();
        @(posedge pclk);
        #3 rstn = 1'b0;
        repeat (2) @(posedge pclk);
        #3 rstn = 1'b1;
    endtask

    function automatic req_t mk(input int addr, input int data);
        req_t r;
        r.addr = AW'(addr);
        r.data = DW'(data);
        return r;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        // Reset held with a pending req0: outputs must stay zero.
        q0.push_back(mk(16'h0010, 12'hF00));
        repeat (4) @(posedge pclk);
        #3 rstn = 1'b1;
        drain(200);

        // Contention from reset: alternating grants.
        reset_pulse();
        @(posedge pclk); #2;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(100 + i, 12'h100 + i));
            q1.push_back(mk(200 + i, 12'h200 + i));
        end
        drain(200);

        // Full-frame clear.
        @(posedge pclk); #2;
        clr_color = 12'h0F0;
        start_pending = 1'b1;
        drain(TOT + 200);

        // Clear and req1 arriving together: clear wins, req1 waits.
        @(posedge pclk); #2;
        clr_color = 12'h5A5;
        q1.push_back(mk(1234, 12'hABC));
        start_pending = 1'b1;
        drain(TOT + 200);

        // Out-of-range addresses at and beyond the frame end.
        @(posedge pclk); #2;
        q0.push_back(mk(TOT, 12'h111));
        q0.push_back(mk(32767, 12'h222));
        q1.push_back(mk(TOT - 1, 12'h333));
        drain(200);

        // Randomized traffic with occasional out-of-range addresses.
        for (int i = 0; i < 200; i++) begin
            @(posedge pclk); #2;
            if ($urandom_range(0, 2) == 0)
                q0.push_back(mk(($urandom_range(0, 7) == 0) ? $urandom_range(TOT, 32767)
                                                            : $urandom_range(0, TOT - 1),
                                $urandom));
            if ($urandom_range(0, 2) == 0)
                q1.push_back(mk(($urandom_range(0, 7) == 0) ? $urandom_range(TOT, 32767)
                                                            : $urandom_range(0, TOT - 1),
                                $urandom));
        end
        drain(2000);

        // Reset during a clear aborts it at once; a new clear starts from 0.
        @(posedge pclk); #2;
        clr_color = 12'h00F;
        start_pending = 1'b1;
        repeat (1002) @(posedge pclk);
        #3 rstn = 1'b0;
        #1 check("async_abort",
                 {clr_busy, clr_done, bus.req0_ready, bus.req1_ready,
                  bus.web, bus.err_oob, bus.addrb, bus.dinb}, 64'd0);
        repeat (3) @(posedge pclk);
        #3 rstn = 1'b1;
        repeat (20) @(posedge pclk);
        #2;
        clr_color = 12'h777;
        start_pending = 1'b1;
        drain(TOT + 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
